// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Sub-word load/store sequencer placed in front of a word-wide data memory.
// It takes one byte, halfword or word load/store from the execute stage and
// issues only word-aligned memory accesses. SB/SH are done as
// read-modify-write. Load results are sign- or zero-extended.
// Only one request is in flight at a time.
//
// Ports
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   iLoad, iStore            request strobes, sampled while oReady=1
//   iFunct3                  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   iAddress, iWData         byte address and store data
//   oReady                   unit idle and accepting a request
//   oDone, oError            one-cycle completion pulse; error qualifies it
//   oRData                   extended load data, held until the next load
//   oMemAddress, oMemData    word-aligned address and write data to memory
//   oMemWrite, oMemRead      single-cycle memory strobes (all registered)
//   iMemData                 memory read data, valid one cycle after the read
module load_store_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iLoad,
  input  logic        iStore,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWData,
  output logic        oReady,
  output logic        oDone,
  output logic        oError,
  output logic [31:0] oRData,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemData,
  output logic        oMemWrite,
  output logic        oMemRead,
  input  logic [31:0] iMemData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Reject a request when both strobes are high, when funct3 is not a legal
  // width for the access type, or when the address is not aligned to it.
  function automatic logic req_error(input logic       ld,
                                     input logic       st,
                                     input logic [2:0] f3,
                                     input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (ld && st) begin
      bad = 1'b1;
    end else if (ld) begin
      case (f3)
        3'd0, 3'd4: bad = 1'b0;
        3'd1, 3'd5: bad = a[0];
        3'd2:       bad = (a != 2'd0);
        default:    bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0:    bad = 1'b0;
        3'd1:    bad = a[0];
        3'd2:    bad = (a != 2'd0);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // Pick the addressed lane of a little-endian word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'd0:    res = {{24{sh[7]}}, sh[7:0]};
      3'd1:    res = {{16{sh[15]}}, sh[15:0]};
      3'd4:    res = {24'h0, sh[7:0]};
      3'd5:    res = {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] data;
    if (f3 == 3'd0) begin
      mask = 32'h0000_00FF << {lane, 3'b000};
      data = {24'h0, wd[7:0]} << {lane, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {lane, 3'b000};
      data = {16'h0, wd} << {lane, 3'b000};
    end
    return (word & ~mask) | (data & mask);
  endfunction

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iLoad || iStore) begin
          lane_d     = iAddress[1:0];
          funct3_d   = iFunct3;
          store_d    = iStore;
          wdata_d    = iWData[15:0];
          mem_addr_d = {iAddress[31:2], 2'b00};
          if (req_error(iLoad, iStore, iFunct3, iAddress[1:0])) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (iStore && (iFunct3 == 3'd2)) begin
            // Full-word store needs no read-back.
            mem_write_d = 1'b1;
            mem_data_d  = iWData;
            state_d     = S_WRITE;
          end else begin
            // Loads and sub-word stores both start with a word read.
            mem_read_d = 1'b1;
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        // Memory samples the read strobe here; data arrives next cycle.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (store_q) begin
          mem_data_d  = store_merge(iMemData, wdata_q, funct3_q, lane_q);
          mem_write_d = 1'b1;
          state_d     = S_WRITE;
        end else begin
          rdata_d = load_extend(iMemData, funct3_q, lane_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'd0;
      funct3_q    <= 3'd0;
      store_q     <= 1'b0;
      wdata_q     <= 16'h0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_data_q  <= 32'h0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign oReady      = (state_q == S_IDLE);
  assign oDone       = done_q;
  assign oError      = error_q;
  assign oRData      = rdata_q;
  assign oMemAddress = mem_addr_q;
  assign oMemData    = mem_data_q;
  assign oMemWrite   = mem_write_q;
  assign oMemRead    = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed requests, expected responses queued
// on issue and compared by a separate monitor whenever oDone pulses.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        iLoad = 1'b0;
  logic        iStore = 1'b0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] iAddress = 32'h0;
  logic [31:0] iWData = 32'h0;
  logic        oReady, oDone, oError, oMemWrite, oMemRead;
  logic [31:0] oRData, oMemAddress, oMemData, iMemData;

  load_store_unit dut (
    .clock(clock), .reset_n(reset_n), .iLoad(iLoad), .iStore(iStore),
    .iFunct3(iFunct3), .iAddress(iAddress), .iWData(iWData),
    .oReady(oReady), .oDone(oDone), .oError(oError), .oRData(oRData),
    .oMemAddress(oMemAddress), .oMemData(oMemData),
    .oMemWrite(oMemWrite), .oMemRead(oMemRead), .iMemData(iMemData)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Word memory model: reads return data the cycle after the strobe.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mem_rdata = 32'h0;
  assign iMemData = mem_rdata;
  always @(posedge clock) begin
    if (oMemWrite) mem[oMemAddress] = oMemData;
    if (oMemRead) mem_rdata <= mem.exists(oMemAddress) ? mem[oMemAddress] : 32'h0;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe sanity plus scoreboard pop on every oDone.
  int mon_rd = 0;
  int mon_wr = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      mon_rd = 0;
      mon_wr = 0;
    end else begin
      if (oMemRead && oMemWrite) chk("strobe_overlap", 32'(1), 32'(0));
      if (oMemRead || oMemWrite) chk("mem_addr_align", 32'(oMemAddress[1:0]), 32'(0));
      if (oMemRead) mon_rd++;
      if (oMemWrite) mon_wr++;
      if (oError && !oDone) chk("error_without_done", 32'(1), 32'(0));
      if (oDone) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("error_flag", 32'(oError), 32'(e.err));
          chk("rdata", oRData, e.rdata);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("read_strobes", 32'(mon_rd), 32'(e.nrd));
          chk("write_strobes", 32'(mon_wr), 32'(e.nwr));
        end
        mon_rd = 0;
        mon_wr = 0;
      end
    end
  end

  logic [31:0] last_rd = 32'h0;

  task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int lat, input int nrd, input int nwr);
    exp_t e;
    int n;
    n = 0;
    @(negedge clock);
    while (!oReady && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (!oReady) chk("ready_timeout", 32'(0), 32'(1));
    iLoad = ld; iStore = st; iFunct3 = f3; iAddress = addr; iWData = wd;
    @(posedge clock);
    #1;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
    e.nrd = nrd; e.nwr = nwr; e.acc = cyc;
    sbq.push_back(e);
    iLoad = 1'b0; iStore = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    req(1'b1, 1'b0, f3, addr, 32'h0, exp, 1'b0, 2, 1, 0);
    last_rd = exp;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    if (f3 == 3'd2) req(1'b0, 1'b1, f3, addr, wd, last_rd, 1'b0, 1, 0, 1);
    else            req(1'b0, 1'b1, f3, addr, wd, last_rd, 1'b0, 3, 1, 1);
  endtask

  task automatic do_bad(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr);
    req(ld, st, f3, addr, 32'hCAFE_F00D, last_rd, 1'b1, 0, 0, 0);
  endtask

  initial begin
    int n;
    mem[32'h1001_0008] = 32'h80FF_7F01;
    mem[32'h1001_000C] = 32'h1122_3344;

    // Reset state
    #12;
    chk("rst_ready", 32'(oReady), 32'(1));
    chk("rst_done", 32'(oDone), 32'(0));
    chk("rst_error", 32'(oError), 32'(0));
    chk("rst_rdata", oRData, 32'h0);
    chk("rst_addr", oMemAddress, 32'h0);
    chk("rst_mdata", oMemData, 32'h0);
    chk("rst_strobes", 32'({oMemWrite, oMemRead}), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // Mid-operation reset: start an SB, reset while in READ.
    @(negedge clock);
    iStore = 1'b1; iFunct3 = 3'd0; iAddress = 32'h1001_000D; iWData = 32'h0000_0055;
    @(posedge clock);
    #1;
    iStore = 1'b0;
    chk("midrst_read_issued", 32'(oMemRead), 32'(1));
    chk("midrst_busy", 32'(oReady), 32'(0));
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(oReady), 32'(1));
    chk("midrst_strobes", 32'({oMemWrite, oMemRead}), 32'(0));
    chk("midrst_addr", oMemAddress, 32'h0);
    chk("midrst_done", 32'({oDone, oError}), 32'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    #1;
    chk("no_write_after_reset", 32'(mon_wr), 32'(0));
    chk("mem_untouched", mem[32'h1001_000C], 32'h1122_3344);

    // SW then LW
    do_store(3'd2, 32'h1001_0004, 32'hDEAD_BEEF);
    do_load (3'd2, 32'h1001_0004, 32'hDEAD_BEEF);

    // Byte/half extraction from 0x80FF7F01
    do_load(3'd0, 32'h1001_000B, 32'hFFFF_FF80);
    do_load(3'd4, 32'h1001_000B, 32'h0000_0080);
    do_load(3'd0, 32'h1001_0008, 32'h0000_0001);
    do_load(3'd1, 32'h1001_000A, 32'hFFFF_80FF);
    do_load(3'd5, 32'h1001_000A, 32'h0000_80FF);
    do_load(3'd4, 32'h1001_0009, 32'h0000_007F);

    // Read-modify-write on 0x11223344; requests while busy are ignored.
    do_store(3'd0, 32'h1001_000D, 32'h1234_56AA);
    iLoad = 1'b1; iFunct3 = 3'd2; iAddress = 32'h1001_0004;
    repeat (2) @(posedge clock);
    #1;
    iLoad = 1'b0;
    do_load (3'd2, 32'h1001_000C, 32'h1122_AA44);
    do_store(3'd1, 32'h1001_000E, 32'h7777_BEEF);
    do_load (3'd2, 32'h1001_000C, 32'hBEEF_AA44);

    // Error cases: no strobes, oRData unchanged
    do_bad(1'b1, 1'b0, 3'd2, 32'h1001_0002);
    do_bad(1'b0, 1'b1, 3'd1, 32'h1001_0001);
    do_bad(1'b1, 1'b0, 3'd3, 32'h1001_0008);
    do_bad(1'b1, 1'b1, 3'd2, 32'h1001_0008);
    do_bad(1'b0, 1'b1, 3'd4, 32'h1001_0008);
    do_bad(1'b1, 1'b0, 3'd5, 32'h1001_0009);

    // Back-to-back after errors still works
    do_load(3'd1, 32'h1001_0008, 32'h0000_7F01);

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
    chk("mem_final", mem[32'h1001_000C], 32'hBEEF_AA44);
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
